ip_fetch_unit: RTL and testbench
================================

# ip_fetch_unit

Instruction fetch stage directly downstream of the IP selection mux. Holds the instruction pointer register, loads it from the mux output on redirect, and issues one-outstanding word reads to instruction memory. Fetched words are buffered in a small in-order queue toward decode. It also returns `ip_cur + 4` to the mux as its sequential source.

## Interface
Parameters:
- `IQ_DEPTH`, default 4: instruction queue entries; must be a power of 2 and at least 2.
- `RESET_IP`, default 32'h0000_0000: IP value after reset; word aligned.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ip_next`  in  32  redirect target from the IP mux output.
- `ip_ld`  in  1  load `ip_next` into the IP register and flush the stage.
- `ip_cur`  out  32  current IP register, the address of the next fetch.
- `ip_plus4`  out  32  `ip_cur + 4`, mod 2^32; feeds the mux sequential input.
- `mem_req`  out  1  fetch request valid.
- `mem_addr`  out  32  fetch address; equals `ip_cur`.
- `mem_gnt`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.
- `ir_valid`  out  1  queue head valid.
- `ir_data`  out  32  instruction word at the queue head.
- `ir_pc`  out  32  address of `ir_data`.
- `ir_ready`  in  1  decode consumes the head this cycle.

## Operation
- **FSM states: FETCH, WAIT, DROP.** Reset state is FETCH.
- **FETCH**
  - `mem_req` = !reset && (count < IQ_DEPTH).
  - On `mem_req && mem_gnt`: `req_pc <= ip_cur`; `ip_cur <= ip_cur + 4`; go to WAIT.
- **WAIT**
  - `mem_req` = 0.
  - On `mem_rvalid`: push {`req_pc`, `mem_rdata`}; go to FETCH.
  - The queue slot is reserved at grant, so a push never overflows.
- **DROP**
  - `mem_req` = 0.
  - On `mem_rvalid`: discard the data; go to FETCH.
- **Redirect (`ip_ld` = 1)**
  - `ip_cur <= {ip_next[31:2], 2'b00}`.
  - The queue is emptied, overriding any push or pop that cycle.
  - State on the next cycle:
    - DROP if a request is outstanding: state is WAIT without `mem_rvalid` this cycle, or FETCH with `mem_gnt` this cycle.
    - Otherwise FETCH.
  - A request granted in the redirect cycle does not advance IP; the loaded value wins.
  - `ip_ld` while in DROP stays in DROP until `mem_rvalid`.
- **Pop:** `ir_valid && ir_ready` removes the head. A push and a pop in the same cycle leave `count` unchanged.
- **Queue outputs:**
  - `ir_valid` = (count != 0).
  - `ir_data` and `ir_pc` reflect the head entry storage.
  - The queue is circular, with read and write pointers of width log2(IQ_DEPTH) that wrap naturally.
- **Arithmetic:** IP increments by 4 modulo 2^32; 32'hFFFF_FFFC wraps to 0. `mem_rdata` is never modified.

## Timing
- **Reset:** in the cycle `reset` is high, all state clears on the edge and `mem_req` = 0. After reset:
  - `ip_cur` = RESET_IP, `ip_plus4` = RESET_IP + 4.
  - `ir_valid` = 0, `ir_data` = 0, `ir_pc` = 0, count = 0, state FETCH.
  - Reset mid-transaction drops the outstanding request; a later `mem_rvalid` in FETCH is ignored.
- **Request hold:** `mem_req` and `mem_addr` stay stable until `mem_gnt` unless `ip_ld` or `reset` occurs.
- **Memory latency:** `mem_rvalid` must arrive at least 1 cycle after grant.
- **Fetch latency:** without bypass, the minimum from grant to `ir_valid` is grant + 2 cycles, with a response latency of 1.
- **Throughput:** at most one fetch per 2 cycles, since FETCH is re-entered after each response.
- **Decode stall:** `ir_data` and `ir_pc` hold while `ir_valid && !ir_ready`.
- **`ip_plus4`:** combinational from `ip_cur`, zero added latency.

## Configuration
- **Macro:** `IPF_BYPASS_EN`.
- **Defined:**
  - When the queue is empty and `mem_rvalid` is high in WAIT, `ir_valid` = 1 and `ir_data`/`ir_pc` = `mem_rdata`/`req_pc` combinationally in that same cycle.
  - If `ir_ready` is also high, the word is consumed without entering the queue. Otherwise it is pushed as normal.
  - Bypass is suppressed in DROP and when `ip_ld` = 1.
- **Undefined:** responses always enter the queue and become visible on the following cycle.

## Test plan
- **Reset:** RESET_IP = 32'h100, hold `reset` 2 cycles -> `mem_req` = 0 during reset; then `mem_req` = 1 with `mem_addr` = 32'h100 and `ir_valid` = 0.
- **Sequential fetch:** immediate `mem_gnt`, `mem_rvalid` 1 cycle later with data 32'hA0, A1, A2, `ir_ready` = 1 -> `ir_pc` sequence 100, 104, 108 with matching data, and `ip_plus4` = `ip_cur` + 4 throughout.
- **Back-pressure:** `ir_ready` = 0 with IQ_DEPTH = 4 -> exactly 4 grants, then `mem_req` = 0. Raising `ir_ready` for 1 cycle -> one pop and one new request.
- **Redirect with outstanding request:** `ip_ld` = 1, `ip_next` = 32'h203 while in WAIT -> `ip_cur` = 32'h200 and the queue empties. The pending response is discarded. The next `mem_addr` = 32'h200, and the first `ir_pc` after redirect = 32'h200.
- **Wrap-around:** `ip_ld` to 32'hFFFF_FFFC, fetch 2 words -> `ir_pc` = FFFF_FFFC then 0000_0000.
- **Bypass, `IPF_BYPASS_EN` defined:** empty queue, `ir_ready` = 1, `mem_rvalid` with 32'hDEAD_BEEF -> `ir_valid` = 1 and `ir_data` = DEAD_BEEF in the same cycle, and count remains 0.

Source files
------------

// File: rtl/ip_fetch_unit.sv
// rtl/ip_fetch_unit.sv - instruction fetch stage: IP register, one-outstanding fetch, in-order instruction queue
// Optional same-cycle response bypass to decode is enabled by defining IPF_BYPASS_EN.
module ip_fetch_unit #(
   parameter int          IQ_DEPTH = 4,
   parameter logic [31:0] RESET_IP = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ip_next,
   input  logic        ip_ld,
   output logic [31:0] ip_cur,
   output logic [31:0] ip_plus4,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        ir_valid,
   output logic [31:0] ir_data,
   output logic [31:0] ir_pc,
   input  logic        ir_ready
);
   localparam int          AW      = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(IQ_DEPTH);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;
   state_t state, state_nxt;

   logic [31:0]   ip_q;
   logic [31:0]   req_pc;
   logic [31:0]   q_data [IQ_DEPTH];
   logic [31:0]   q_pc   [IQ_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          grant, push, q_pop, bypass;
   logic          unused_ip_lsb;

   assign unused_ip_lsb = ^ip_next[1:0];

   assign ip_cur   = ip_q;
   assign ip_plus4 = ip_q + 32'd4;
   assign mem_addr = ip_q;
   // Only one request may be in flight, and its queue slot is reserved at grant.
   assign mem_req  = !reset && (state == S_FETCH) && (count < DEPTH_C);
   assign grant    = mem_req && mem_gnt;

`ifdef IPF_BYPASS_EN
   assign bypass = (state == S_WAIT) && mem_rvalid && (count == '0) && !ip_ld;
`else
   assign bypass = 1'b0;
`endif

   assign ir_valid = (count != '0) || bypass;
   assign ir_data  = bypass ? mem_rdata : q_data[rd_ptr];
   assign ir_pc    = bypass ? req_pc    : q_pc[rd_ptr];
   assign q_pop    = (count != '0) && ir_ready;
   assign push     = (state == S_WAIT) && mem_rvalid && !(bypass && ir_ready);

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: if (grant) state_nxt = ip_ld ? S_DROP : S_WAIT;
         S_WAIT: begin
            if (mem_rvalid)  state_nxt = S_FETCH;
            else if (ip_ld)  state_nxt = S_DROP;
         end
         S_DROP:  if (mem_rvalid) state_nxt = S_FETCH;
         default: state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_FETCH;
         ip_q   <= RESET_IP;
         req_pc <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < IQ_DEPTH; i++) begin
            q_data[i] <= '0;
            q_pc[i]   <= '0;
         end
      end else begin
         state <= state_nxt;
         if (grant) req_pc <= ip_q;
         // A redirect flushes the queue and beats any increment, push or pop.
         if (ip_ld) begin
            ip_q   <= {ip_next[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (grant) ip_q <= ip_q + 32'd4;
            if (push) begin
               q_data[wr_ptr] <= mem_rdata;
               q_pc[wr_ptr]   <= req_pc;
               wr_ptr         <= wr_ptr + AW'(1);
            end
            if (q_pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !q_pop)      count <= count + (AW + 1)'(1);
            else if (!push && q_pop) count <= count - (AW + 1)'(1);
         end
      end
   end
endmodule

// File: tb/tb_ip_fetch_unit.sv
// tb/tb_ip_fetch_unit.sv - randomized self-checking bench for ip_fetch_unit against a queue-based reference model
module tb_ip_fetch_unit;
   localparam int          IQ_DEPTH = 4;
   localparam logic [31:0] RESET_IP = 32'h100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ip_next = '0;
   logic        ip_ld = 1'b0;
   logic [31:0] ip_cur, ip_plus4, mem_addr, ir_data, ir_pc;
   logic        mem_req, ir_valid;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        ir_ready = 1'b0;

   ip_fetch_unit #(.IQ_DEPTH(IQ_DEPTH), .RESET_IP(RESET_IP)) dut (
      .clk(clk), .reset(reset), .ip_next(ip_next), .ip_ld(ip_ld),
      .ip_cur(ip_cur), .ip_plus4(ip_plus4), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   ent_t        q[$];
   logic [31:0] exp_ip = RESET_IP;
   logic        pending = 1'b0;
   logic        pend_drop = 1'b0;
   logic [31:0] pend_pc = '0;
   int          lat_cnt = 0;
   int          lat_lo = 0;
   int          lat_hi = 0;
   logic        force_rv = 1'b0;
   int          n_grants = 0;
   int          n_pops = 0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic rst, input logic ld, input logic [31:0] nxt,
                        input logic gnt, input logic rdy);
      logic        resp, exp_req, byp, exp_irv, grant, pop;
      logic [31:0] rdat;
      @(negedge clk);
      resp = pending && (lat_cnt == 0) && !rst;
      rdat = $urandom;
      reset = rst; ip_ld = ld; ip_next = nxt; mem_gnt = gnt;
      mem_rvalid = resp || force_rv; mem_rdata = rdat; ir_ready = rdy;
      #1;
      exp_req = !rst && !pending && (q.size() < IQ_DEPTH);
      byp = 1'b0;
`ifdef IPF_BYPASS_EN
      byp = resp && !pend_drop && !ld && (q.size() == 0);
`endif
      exp_irv = (q.size() != 0) || byp;
      chk("mem_req", mem_req, exp_req);
      if (exp_req) chk("mem_addr", mem_addr, exp_ip);
      chk("ip_cur", ip_cur, exp_ip);
      chk("ip_plus4", ip_plus4, exp_ip + 32'd4);
      chk("ir_valid", ir_valid, exp_irv);
      if (exp_irv) begin
         chk("ir_pc", ir_pc, byp ? pend_pc : q[0].pc);
         chk("ir_data", ir_data, byp ? rdat : q[0].data);
      end
      grant = exp_req && gnt;
      pop   = exp_irv && rdy;
      if (grant) n_grants++;
      if (pop && !rst && !ld) n_pops++;
      if (pending && !resp && lat_cnt != 0) lat_cnt--;
      if (rst) begin
         q.delete();
         pending = 1'b0;
         exp_ip  = RESET_IP;
      end else if (ld) begin
         q.delete();
         pending   = (pending && !resp) || grant;
         pend_drop = 1'b1;
         if (grant) lat_cnt = $urandom_range(lat_hi, lat_lo);
         exp_ip = {nxt[31:2], 2'b00};
      end else begin
         if (pop && !byp) void'(q.pop_front());
         if (resp && !pend_drop && !(byp && rdy)) q.push_back('{pc: pend_pc, data: rdat});
         if (resp) pending = 1'b0;
         if (grant) begin
            pending   = 1'b1;
            pend_drop = 1'b0;
            pend_pc   = exp_ip;
            exp_ip    = exp_ip + 32'd4;
            lat_cnt   = $urandom_range(lat_hi, lat_lo);
         end
      end
   endtask

   initial begin
      int g0, p0;
      logic [31:0] nxt;

      // reset held two cycles, then first request at RESET_IP
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("rst_addr", mem_addr, 32'h100);
      chk("rst_ir_data", ir_data, 32'h0);
      chk("rst_ir_pc", ir_pc, 32'h0);

      // sequential fetch with immediate grant and 1-cycle response
      lat_lo = 0; lat_hi = 0;
      p0 = n_pops;
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 1);
`ifdef IPF_BYPASS_EN
      chk("seq_pops", n_pops - p0, 4);
`else
      chk("seq_pops", n_pops - p0, 3);
`endif

      // back-pressure: queue fills after exactly IQ_DEPTH grants
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 32'h300, 0, 0);
      lat_hi = 2;
      g0 = n_grants;
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 0);
      chk("bp_grants", n_grants - g0, IQ_DEPTH);
      chk("bp_req_off", mem_req, 1'b0);
      cycle(0, 0, 0, 1, 1);
      g0 = n_grants;
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
      chk("bp_one_more", n_grants - g0, 1);

      // redirect while a request is outstanding
      cycle(0, 1, 32'h400, 0, 1);
      lat_lo = 2; lat_hi = 2;
      cycle(0, 0, 0, 1, 1);
      cycle(0, 1, 32'h203, 0, 1);
      cycle(0, 0, 0, 0, 1);
      chk("redir_ip", ip_cur, 32'h200);
      chk("redir_flush", ir_valid, 1'b0);
      chk("redir_drop_req", mem_req, 1'b0);
      cycle(0, 0, 0, 0, 1);
      lat_lo = 0; lat_hi = 0;
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 1);
`ifndef IPF_BYPASS_EN
      cycle(0, 0, 0, 0, 1);
      chk("redir_pc", ir_pc, 32'h200);
`endif
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);

      // wrap-around at the top of the address space
      cycle(0, 1, 32'hFFFF_FFFC, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
      chk("wrap_pc", ir_pc, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);
      chk("wrap_pc2", ir_pc, 32'h0);

      // reset mid-transaction, stale response afterwards is ignored
      lat_lo = 2; lat_hi = 2;
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 1);
      cycle(1, 0, 0, 0, 0);
      force_rv = 1'b1;
      cycle(0, 0, 0, 0, 0);
      force_rv = 1'b0;
      cycle(0, 0, 0, 0, 0);
      chk("rst_stale_v", ir_valid, 1'b0);
      chk("rst_ip", ip_cur, 32'h100);

      // randomized traffic
      lat_lo = 0; lat_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         nxt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 19) == 0), nxt,
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
